// File: rtl/shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/shift_stage.sv
// One log-stage of the barrel shifter: shift by 2^K when shamt bit K is set, then register.
// Optional carry tracking is enabled by the SHIFTER_FLAGS_EN macro.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  TAG_W   = 4,
    parameter int  K       = 0,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         mode_i,
    input  logic [TAG_W-1:0]   tag_i,
`ifdef SHIFTER_FLAGS_EN
    input  logic               carry_i,
    output logic               carry_o,
`endif
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [1:0]         mode_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   data_d;
    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         mode_q;
    logic [TAG_W-1:0]   tag_q;

    always_comb begin
        shifted = data_i;
        case (shift_mode_t'(mode_i))
            SHIFT_SLL: shifted = data_i << S;
            SHIFT_SRL: shifted = data_i >> S;
            SHIFT_SRA: shifted = $unsigned($signed(data_i) >>> S);
            SHIFT_ROR: shifted = {data_i[S-1:0], data_i[WIDTH-1:S]};
            default:   shifted = data_i;
        endcase
    end

    assign data_d = shamt_i[K] ? shifted : data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            shamt_q <= shamt_i;
            mode_q  <= mode_i;
            tag_q   <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign tag_o   = tag_q;

`ifdef SHIFTER_FLAGS_EN
    // A shifting stage replaces the running carry with the last bit it pushes out.
    logic shift_carry;
    logic carry_d;
    logic carry_q;

    always_comb begin
        shift_carry = (mode_i == SHIFT_SLL) ? data_i[WIDTH-S] : data_i[S-1];
        carry_d     = shamt_i[K] ? shift_carry : carry_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (en_i) begin
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and a final output register.
// Define SHIFTER_FLAGS_EN to add the out_zero/out_carry flag outputs.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
`ifdef SHIFTER_FLAGS_EN
    output logic               out_zero,
    output logic               out_carry,
`endif
    output logic               busy
);

    // Index 0 is the stage-0 input; index k+1 is the register output of stage k.
    logic               valid_s [0:SHAMT_W];
    logic [WIDTH-1:0]   data_s  [0:SHAMT_W];
    logic [SHAMT_W-1:0] shamt_s [0:SHAMT_W];
    logic [1:0]         mode_s  [0:SHAMT_W];
    logic [TAG_W-1:0]   tag_s   [0:SHAMT_W];

    logic               adv;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [TAG_W-1:0]   out_tag_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !rst;

    // An empty stage-0 slot is loaded with cleared payload.
    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_valid ? in_data : '0;
    assign shamt_s[0] = in_valid ? in_shamt : '0;
    assign mode_s[0]  = in_valid ? in_mode : '0;
    assign tag_s[0]   = in_valid ? in_tag : '0;

`ifdef SHIFTER_FLAGS_EN
    logic carry_s [0:SHAMT_W];
    assign carry_s[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .shamt_i (shamt_s[k]),
            .mode_i  (mode_s[k]),
            .tag_i   (tag_s[k]),
`ifdef SHIFTER_FLAGS_EN
            .carry_i (carry_s[k]),
            .carry_o (carry_s[k+1]),
`endif
            .valid_o (valid_s[k+1]),
            .data_o  (data_s[k+1]),
            .shamt_o (shamt_s[k+1]),
            .mode_o  (mode_s[k+1]),
            .tag_o   (tag_s[k+1])
        );
    end

    // Output register: holds the presented result stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= valid_s[SHAMT_W];
            out_data_q  <= data_s[SHAMT_W];
            out_tag_q   <= tag_s[SHAMT_W];
        end
    end

`ifdef SHIFTER_FLAGS_EN
    logic out_zero_q;
    logic out_carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
        end else if (adv) begin
            out_zero_q  <= (data_s[SHAMT_W] == '0);
            out_carry_q <= carry_s[SHAMT_W];
        end
    end

    assign out_zero  = out_zero_q;
    assign out_carry = out_carry_q;
`endif

    always_comb begin
        busy = out_valid_q;
        for (int k = 1; k <= SHAMT_W; k++) begin
            busy = busy | valid_s[k];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined barrel shifter that succeeds the 16-bit combinational SLL/SRA shifter used by the ALU.
- Supports four modes: SLL, SRL, SRA, ROR.
- Generalised in WIDTH; one registered log-stage per shift-amount bit.
- Uses a valid/ready handshake so it can sit between issue and writeback in the pipelined datapath with backpressure.

Parameters:
- WIDTH, 16, data width; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; not to be overridden.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, block accepts an operation this cycle.
- in_data, input, WIDTH, operand.
- in_shamt, input, SHAMT_W, shift amount 0..WIDTH-1.
- in_mode, input, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag, input, TAG_W, opaque sideband (e.g. destination register).
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, WIDTH, shifted result.
- out_tag, output, TAG_W, tag of the result.
- busy, output, 1, any pipeline stage holds a valid operation.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous, active-high.
- Reset values (async on rst): all stage valid bits 0, out_valid 0, out_data 0, out_tag 0, busy 0.
- in_ready is forced to 0 while rst is high.
- Pipeline structure: SHAMT_W stages. Stage k (k = 0..SHAMT_W-1) shifts by 2^k when shamt bit k is 1, otherwise passes data through. Each stage's output is registered.
- Stage registers hold valid, data, shamt, mode and tag.
- Stage k+1 uses the shamt and mode carried in stage k's registers, not the live inputs.
- Latency: a transfer accepted at edge N produces out_valid at edge N+SHAMT_W with no backpressure (4 cycles for WIDTH=16). Throughput is one operation per cycle.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv && !rst.
  - When adv = 0, every stage register holds its value.
  - Bubbles are not compressed.
- Transfers: input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
- Output stability: while out_valid && !out_ready, out_data and out_tag hold stable.
- Per-stage shift rules:
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: the current MSB is replicated at the top.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- in_shamt = 0 in any mode: out_data = in_data.
- Stage 0 empty slot: when in_valid is 0 and adv is 1, stage 0 loads valid = 0; its data is don't-care but is cleared to 0.
- Simultaneous input and output transfer in the same cycle is legal and sustains full throughput.
- busy is the OR of all stage valid bits.
- Reset mid-operation drops all in-flight operations; no result is emitted for them.
- Mode 2'b11 is always ROR; there are no illegal encodings.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined, two extra output ports are added, each registered, stalled and reset with the pipeline:
  - out_zero, 1: out_data == 0.
  - out_carry, 1: the last bit shifted out of the operand. For SLL it is the last bit leaving the MSB; for SRL/SRA/ROR it is the last bit leaving the LSB. It is 0 when shamt = 0.
- Carry is tracked per stage. A stage that shifts replaces the running carry; a stage that passes through keeps it.
- When undefined, the ports are absent and no flag logic or registers exist.

Decomposition:
- Package shifter_pkg holds:
  - the mode typedef (2-bit enum SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR);
  - the constant DEFAULT_WIDTH = 16.
- Sub-module shift_stage, parametrised by WIDTH, TAG_W and STAGE index k:
  - combinational shift-by-2^k plus the stage register set (valid, data, shamt, mode, tag, optional carry), with an enable input;
  - pipelined_shifter instantiates SHAMT_W of them in a generate loop and owns adv, in_ready, out_zero and busy.

Test Plan:
- WIDTH=16, out_ready=1, one op: in_data=16'h8001, shamt=1, mode SRA -> out_data=16'hC000, out_valid exactly 4 cycles after acceptance. With flags: carry=1, zero=0.
- Back-to-back ops, one per cycle: SLL 16'h0001 by 15 -> 16'h8000; SRL 16'h8000 by 15 -> 16'h0001; ROR 16'h00F1 by 4 -> 16'h100F; SRA 16'h7FFF by 15 -> 16'h0000 (with flags: zero=1). Results in order, tags 1..4 preserved, no bubbles.
- Backpressure: out_ready held 0 for 3 cycles while the result is valid -> in_ready=0, out_data/out_tag stable, no loss or duplication. After release, the remaining results emerge in order.
- Reset asserted with 3 ops in flight -> out_valid, busy and in_ready go 0 immediately. After deassert there are no stale outputs, and a new op (SLL 16'h0003 by 2 -> 16'h000C) completes normally.
- shamt=0 in all four modes with in_data=16'hA5A5 -> out_data=16'hA5A5; with flags, carry=0.
- WIDTH=32, TAG_W=6: SRA 32'h80000000 by 31 -> 32'hFFFFFFFF with latency 5; ROR 32'h00000001 by 1 -> 32'h80000000.
